// File: rtl/lsu_dccm_stbuf.sv
// Four-entry in-order store buffer between LSU commit and the single-ported DCCM.
// Drains to the DCCM write port when the load pipe leaves the port idle, and flags loads that hit pending stores.
module lsu_dccm_stbuf #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 39
) (
   input  logic                       clk,
   input  logic                       rst_l,
   input  logic                       lsu_freeze_dc3,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic                       ld_rden,
   input  logic [ADDR_W-1:0]          ld_addr_lo,
   input  logic [ADDR_W-1:0]          ld_addr_hi,
   output logic                       ld_stall,
   output logic                       dccm_wren,
   output logic [ADDR_W-1:0]          dccm_wr_addr,
   output logic [DATA_W-1:0]          dccm_wr_data,
   output logic                       stbuf_empty,
   output logic [$clog2(DEPTH):0]     stbuf_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   logic [DEPTH-1:0]  vld;
   logic [WA_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic full;
   logic enq;
   logic drain;
   logic hit;
   logic unused_lsbs;

   assign unused_lsbs = ^{st_addr[1:0], ld_addr_lo[1:0], ld_addr_hi[1:0]};

   assign full        = (count == CNT_W'(DEPTH));
   assign stbuf_empty = (count == '0);
   assign stbuf_count = count;

   // No bypass: a full buffer refuses stores even when it drains this cycle.
   assign st_ready = ~full & ~lsu_freeze_dc3;
   assign enq      = st_valid & st_ready;

   // A full buffer takes the port from the load so a load stream cannot starve the drain.
   assign drain     = ~stbuf_empty & ~lsu_freeze_dc3 & (~ld_rden | full);
   assign dccm_wren = drain;

   assign dccm_wr_addr = {addr_q[rd_ptr], 2'b00};
   assign dccm_wr_data = data_q[rd_ptr];

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && ((addr_q[i] == ld_addr_lo[ADDR_W-1:2]) ||
                        (addr_q[i] == ld_addr_hi[ADDR_W-1:2])))
            hit = 1'b1;
      end
   end

   assign ld_stall = ld_rden & (hit | (full & ~lsu_freeze_dc3));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         vld    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         // Drain and enqueue never target the same slot: drain needs an entry, enqueue needs a free one.
         if (drain) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + PTR_W'(1);
         end
         if (enq) begin
            vld[wr_ptr]    <= 1'b1;
            addr_q[wr_ptr] <= st_addr[ADDR_W-1:2];
            data_q[wr_ptr] <= st_data;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         case ({enq, drain})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Bench for lsu_dccm_stbuf: directed stores, with a scoreboard of expected DCCM writes checked by a monitor.
module tb_lsu_dccm_stbuf;

   logic        clk;
   logic        rst_l;
   logic        lsu_freeze_dc3;
   logic        st_valid;
   logic [15:0] st_addr;
   logic [38:0] st_data;
   logic        st_ready;
   logic        ld_rden;
   logic [15:0] ld_addr_lo;
   logic [15:0] ld_addr_hi;
   logic        ld_stall;
   logic        dccm_wren;
   logic [15:0] dccm_wr_addr;
   logic [38:0] dccm_wr_data;
   logic        stbuf_empty;
   logic [2:0]  stbuf_count;

   typedef struct packed {
      logic [15:0] a;
      logic [38:0] d;
   } wr_t;

   wr_t sb[$];
   int  errors = 0;
   int  checks = 0;

   lsu_dccm_stbuf dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .lsu_freeze_dc3 (lsu_freeze_dc3),
      .st_valid       (st_valid),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_ready       (st_ready),
      .ld_rden        (ld_rden),
      .ld_addr_lo     (ld_addr_lo),
      .ld_addr_hi     (ld_addr_hi),
      .ld_stall       (ld_stall),
      .dccm_wren      (dccm_wren),
      .dccm_wr_addr   (dccm_wr_addr),
      .dccm_wr_data   (dccm_wr_data),
      .stbuf_empty    (stbuf_empty),
      .stbuf_count    (stbuf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [15:0] a, input logic [38:0] d, input logic [15:0] exp_a);
      wr_t e;
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      e.a = exp_a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wren"},  64'(dccm_wren), 64'd0);
      chk({tag, "_waddr"}, 64'(dccm_wr_addr), 64'd0);
      chk({tag, "_wdata"}, 64'(dccm_wr_data), 64'd0);
      chk({tag, "_ready"}, 64'(st_ready), 64'd1);
      chk({tag, "_stall"}, 64'(ld_stall), 64'd0);
      chk({tag, "_empty"}, 64'(stbuf_empty), 64'd1);
      chk({tag, "_count"}, 64'(stbuf_count), 64'd0);
   endtask

   // Monitor: every DCCM write seen must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_l && dccm_wren) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", dccm_wr_addr, dccm_wr_data);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 64'(dccm_wr_addr), 64'(e.a));
            chk("wr_data", 64'(dccm_wr_data), 64'(e.d));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_l          = 1'b0;
      lsu_freeze_dc3 = 1'b0;
      st_valid       = 1'b0;
      st_addr        = '0;
      st_data        = '0;
      ld_rden        = 1'b0;
      ld_addr_lo     = 16'h0F00;
      ld_addr_hi     = 16'h0F00;
      #2;
      chk_reset_vals("rst");
      #10;
      rst_l = 1'b1;
      tick();
      chk_reset_vals("idle");

      // Single store drains the cycle after acceptance
      store(16'h0104, 39'h12_3456_789A, 16'h0104);
      chk("t2_ready", 64'(st_ready), 64'd1);
      tick();
      st_valid = 1'b0;
      #1;
      chk("t2_count", 64'(stbuf_count), 64'd1);
      chk("t2_wren", 64'(dccm_wren), 64'd1);
      tick();
      chk("t2_empty", 64'(stbuf_empty), 64'd1);
      chk("t2_wren0", 64'(dccm_wren), 64'd0);

      // Four stores under a continuous load stream
      ld_rden = 1'b1;
      store(16'h0300, 39'h01_0000_0001, 16'h0300); tick();
      store(16'h0304, 39'h02_0000_0002, 16'h0304); tick();
      store(16'h030B, 39'h03_0000_0003, 16'h0308); tick();
      store(16'h030C, 39'h04_0000_0004, 16'h030C); tick();
      st_valid = 1'b0;
      #1;
      chk("t3_count4", 64'(stbuf_count), 64'd4);
      chk("t3_ready0", 64'(st_ready), 64'd0);
      chk("t3_wren", 64'(dccm_wren), 64'd1);
      chk("t3_stall", 64'(ld_stall), 64'd1);
      tick();
      chk("t3_count3", 64'(stbuf_count), 64'd3);
      chk("t3_ready1", 64'(st_ready), 64'd1);
      chk("t3_wren0", 64'(dccm_wren), 64'd0);
      chk("t3_stall0", 64'(ld_stall), 64'd0);
      ld_rden = 1'b0;
      tick(); tick(); tick();
      chk("t3_empty", 64'(stbuf_empty), 64'd1);

      // Load hit against a pending store
      ld_rden = 1'b1;
      store(16'h0200, 39'h55_AAAA_5555, 16'h0200);
      tick();
      st_valid   = 1'b0;
      ld_addr_lo = 16'h0202;
      ld_addr_hi = 16'h0F00;
      #1;
      chk("t4_hit_lo", 64'(ld_stall), 64'd1);
      ld_addr_lo = 16'h0204;
      ld_addr_hi = 16'h0200;
      #1;
      chk("t4_hit_hi", 64'(ld_stall), 64'd1);
      ld_addr_lo = 16'h0208;
      ld_addr_hi = 16'h0300;
      #1;
      chk("t4_miss", 64'(ld_stall), 64'd0);
      ld_rden = 1'b0;
      tick(); tick();
      chk("t4_empty", 64'(stbuf_empty), 64'd1);

      // Steady enqueue+drain at count 2, wrapping pointers
      ld_rden    = 1'b1;
      ld_addr_lo = 16'h0F00;
      ld_addr_hi = 16'h0F00;
      store(16'h0400, 39'h10_0000_0000, 16'h0400); tick();
      store(16'h0411, 39'h10_0000_0011, 16'h0410); tick();
      ld_rden = 1'b0;
      for (int i = 0; i < 10; i++) begin
         store(16'h0500 + 16'(i * 4), 39'h20_0000_0000 + 39'(i), 16'h0500 + 16'(i * 4));
         tick();
         chk("t5_count", 64'(stbuf_count), 64'd2);
      end
      st_valid = 1'b0;
      tick(); tick();
      chk("t5_empty", 64'(stbuf_empty), 64'd1);

      // Freeze holds state but still reports hits
      ld_rden = 1'b1;
      store(16'h0600, 39'h66_0000_0600, 16'h0600); tick();
      store(16'h0604, 39'h66_0000_0604, 16'h0604); tick();
      lsu_freeze_dc3 = 1'b1;
      st_valid   = 1'b1;
      st_addr    = 16'h0608;
      st_data    = 39'h66_0000_0608;
      ld_addr_lo = 16'h0604;
      #1;
      chk("t6_ready0", 64'(st_ready), 64'd0);
      chk("t6_wren0", 64'(dccm_wren), 64'd0);
      chk("t6_hit", 64'(ld_stall), 64'd1);
      ld_rden = 1'b0;
      #1;
      chk("t6_wren0_nold", 64'(dccm_wren), 64'd0);
      tick();
      chk("t6_count", 64'(stbuf_count), 64'd2);

      // Asynchronous reset while a drain is pending
      lsu_freeze_dc3 = 1'b0;
      st_valid       = 1'b0;
      ld_addr_lo     = 16'h0F00;
      #1;
      chk("t7_wren", 64'(dccm_wren), 64'd1);
      rst_l = 1'b0;
      #1;
      sb.delete();
      chk_reset_vals("t7");
      tick();
      rst_l = 1'b1;
      tick();
      chk("t7_empty_after", 64'(stbuf_empty), 64'd1);

      // Buffer still works after reset
      store(16'h0700, 39'h7F_FFFF_FFFF, 16'h0700); tick();
      st_valid = 1'b0;
      tick(); tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
